sp_stream_unpacker: RTL and testbench

Parametrised service-protocol receive unpacker. It sits between the SPI word receiver and the command dispatcher. It parses the header, payload, checksum and number words of each service packet, and forwards payload words on a registered push bus. It filters packets by module address, checks the additive checksum, and aborts stalled packets on an inter-word timeout. Every error is reported with an error code.

---
 rtl/sp_stream_unpacker_pkg.sv | 42 ++++
 rtl/sp_stream_unpacker_if.sv | 11 +
 rtl/sp_stream_unpacker_timeout_counter.sv | 40 ++++
 rtl/sp_stream_unpacker.sv | 201 ++++++++++++++++++++
 tb/tb_sp_stream_unpacker.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_stream_unpacker_pkg.sv
// Service-protocol definitions shared by the receive unpacker: field widths,
// command codes, error codes and parser states.
package ServiceProtocol;

  localparam int unsigned AddrW = 8;
  localparam int unsigned CmdW  = 8;

  typedef enum logic [CmdW-1:0] {
    CmdNop    = 8'h00,
    CmdRead   = 8'h01,
    CmdWrite  = 8'h02,
    CmdStatus = 8'h03,
    CmdReset  = 8'h04
  } sp_cmd_e;

  typedef enum logic [2:0] {
    ErrNone    = 3'd0,
    ErrBadCmd  = 3'd1,
    ErrCrc     = 3'd2,
    ErrTimeout = 3'd3,
    ErrAbort   = 3'd4
  } TSpError;

  typedef enum logic [2:0] {
    StIdle,
    StHead1,
    StHead2,
    StData,
    StDrop,
    StCrc,
    StNum
  } sp_state_e;

  // CmdNop is reserved on the wire and rejected like any unknown code.
  function automatic logic is_valid_cmd(logic [CmdW-1:0] code);
    case (code)
      CmdRead, CmdWrite, CmdStatus, CmdReset: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sp_stream_unpacker_if.sv
// Word stream with a one-cycle request strobe and a done acknowledge.
interface sp_stream_unpacker_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              request;
  logic [DATA_W-1:0] data;
  logic              done;

  modport master (output request, output data, input done);
  modport slave  (input request, input data, output done);
endinterface

// File: rtl/sp_stream_unpacker_timeout_counter.sv
// Inter-word idle counter: expires after TIMEOUT idle enabled clocks; TIMEOUT of 0 disables.
module sp_timeout_counter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, count_en, clear};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear || !count_en) begin
        cnt_d = '0;
      end else if (cnt_q != Limit) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    // A word arriving on the expiry cycle wins over the timeout.
    assign expired = count_en && !clear && (cnt_q == Limit);
  end

endmodule

// File: rtl/sp_stream_unpacker.sv
// Service-protocol receive unpacker: parses header/payload/checksum/number words,
// forwards payload on a registered push bus and flags packet errors.
module sp_stream_unpacker
  import ServiceProtocol::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter logic [7:0]  MODULE_ADDR = 8'h01,
  parameter logic [7:0]  BCAST_ADDR  = 8'hFF,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  sp_stream_unpacker_if.slave  in_bus,
  sp_stream_unpacker_if.master out_bus,
  output logic                pkt_start,
  output logic                pkt_end,
  output logic                pkt_err,
  output logic [2:0]          err_code,
  output logic [7:0]          hdr_addr,
  output logic [7:0]          hdr_cmd,
  output logic [DATA_W-9:0]   hdr_size,
  output logic [DATA_W-9:0]   word_idx,
  output logic [DATA_W-1:0]   pkt_num,
  output logic                num_valid
);

  localparam int unsigned SizeW = DATA_W - AddrW;
  localparam int unsigned CntW  = SizeW + 1;

  sp_state_e         state_q, state_d;
  logic [DATA_W-1:0] crc_q, crc_d, out_data_q, out_data_d, pkt_num_q, pkt_num_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SizeW-1:0]  hdr_size_q, hdr_size_d, word_idx_q, word_idx_d;
  logic [AddrW-1:0]  hdr_addr_q, hdr_addr_d;
  logic [CmdW-1:0]   hdr_cmd_q, hdr_cmd_d;
  logic              out_req_q, out_req_d, pkt_start_q, pkt_start_d, pkt_end_q, pkt_end_d;
  logic              pkt_err_q, pkt_err_d, num_valid_q, num_valid_d;
  TSpError           err_code_q, err_code_d;

  logic              req, cnt_en, expired;
  logic [DATA_W-1:0] in_data;
  logic [CntW-1:0]   size_ext;

  assign req      = in_bus.request;
  assign in_data  = in_bus.data;
  assign size_ext = {1'b0, hdr_size_q};
  assign cnt_en   = state_q inside {StHead2, StData, StDrop, StCrc, StNum};

  sp_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .count_en (cnt_en),
    .clear    (req),
    .expired  (expired)
  );

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    out_req_d   = 1'b0;
    out_data_d  = out_data_q;
    word_idx_d  = word_idx_q;
    pkt_start_d = 1'b0;
    pkt_end_d   = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = ErrNone;
    num_valid_d = 1'b0;
    hdr_addr_d  = hdr_addr_q;
    hdr_cmd_d   = hdr_cmd_q;
    hdr_size_d  = hdr_size_q;
    pkt_num_d   = pkt_num_q;

    unique case (state_q)
      StIdle: if (enable) state_d = StHead1;
      StHead1: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (req) begin
          hdr_addr_d = in_data[AddrW-1:0];
          crc_d      = in_data;
          state_d    = StHead2;
        end
      end
      default: begin
        if (!enable) begin
          pkt_err_d  = 1'b1;
          err_code_d = ErrAbort;
          state_d    = StIdle;
        end else if (req) begin
          case (state_q)
            StHead2: begin
              crc_d      = crc_q + in_data;
              hdr_size_d = in_data[DATA_W-1:AddrW];
              hdr_cmd_d  = in_data[CmdW-1:0];
              cnt_d      = '0;
              if (!is_valid_cmd(in_data[CmdW-1:0])) begin
                pkt_err_d  = 1'b1;
                err_code_d = ErrBadCmd;
                state_d    = StHead1;
              end else if (hdr_addr_q != MODULE_ADDR && hdr_addr_q != BCAST_ADDR) begin
                state_d = StDrop;
              end else if (in_data[DATA_W-1:AddrW] == '0) begin
                state_d = StCrc;
              end else begin
                state_d = StData;
              end
            end
            StData: begin
              crc_d       = crc_q + in_data;
              out_req_d   = 1'b1;
              out_data_d  = in_data;
              word_idx_d  = cnt_q[SizeW-1:0];
              pkt_start_d = (cnt_q == '0);
              cnt_d       = cnt_q + CntW'(1);
              if (cnt_q == size_ext - CntW'(1)) state_d = StCrc;
            end
            // Swallows payload, checksum and number words silently.
            StDrop: begin
              if (cnt_q == size_ext + CntW'(1)) state_d = StHead1;
              else                              cnt_d   = cnt_q + CntW'(1);
            end
            StCrc: begin
              if (in_data == crc_q) begin
                pkt_end_d = 1'b1;
              end else begin
                pkt_err_d  = 1'b1;
                err_code_d = ErrCrc;
              end
              state_d = StNum;
            end
            StNum: begin
              pkt_num_d   = in_data;
              num_valid_d = 1'b1;
              state_d     = StHead1;
            end
            default: ;
          endcase
        end else if (expired) begin
          pkt_err_d  = 1'b1;
          err_code_d = ErrTimeout;
          state_d    = StHead1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      crc_q       <= '0;
      cnt_q       <= '0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      word_idx_q  <= '0;
      pkt_start_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ErrNone;
      num_valid_q <= 1'b0;
      hdr_addr_q  <= '0;
      hdr_cmd_q   <= '0;
      hdr_size_q  <= '0;
      pkt_num_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      word_idx_q  <= word_idx_d;
      pkt_start_q <= pkt_start_d;
      pkt_end_q   <= pkt_end_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      num_valid_q <= num_valid_d;
      hdr_addr_q  <= hdr_addr_d;
      hdr_cmd_q   <= hdr_cmd_d;
      hdr_size_q  <= hdr_size_d;
      pkt_num_q   <= pkt_num_d;
    end
  end

  assign in_bus.done     = (state_q == StData) ? out_bus.done : req;
  assign out_bus.request = out_req_q;
  assign out_bus.data    = out_data_q;
  assign pkt_start       = pkt_start_q;
  assign pkt_end         = pkt_end_q;
  assign pkt_err         = pkt_err_q;
  assign err_code        = err_code_q;
  assign num_valid       = num_valid_q;
  assign hdr_addr        = hdr_addr_q;
  assign hdr_cmd         = hdr_cmd_q;
  assign hdr_size        = hdr_size_q;
  assign word_idx        = word_idx_q;
  assign pkt_num         = pkt_num_q;

endmodule

// File: tb/tb_sp_stream_unpacker.sv
// Self-checking bench for sp_stream_unpacker: packet table plus timeout, abort and reset sequences.
module tb_sp_stream_unpacker;

  typedef struct packed {
    logic [31:0] stamp;
    logic        oreq;
    logic [15:0] odata;
    logic [7:0]  idx;
    logic        start;
    logic        pend;
    logic        perr;
    logic [2:0]  code;
    logic        nv;
    logic [15:0] num;
  } ev_t;

  typedef struct {
    logic [7:0]       addr;
    logic [7:0]       cmd;
    logic [7:0]       size;
    logic [3:0][15:0] pl;
    logic [15:0]      crc_adj;
    logic [15:0]      num;
    logic             fwd;
    logic [2:0]       code;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic pkt_start, pkt_end, pkt_err, num_valid;
  logic [2:0]  err_code;
  logic [7:0]  hdr_addr, hdr_cmd, hdr_size, word_idx;
  logic [15:0] pkt_num;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [15:0] last_num = 16'h0;
  ev_t  sb[$];
  vec_t vecs[8];

  sp_stream_unpacker_if #(.DATA_W(16)) in_if ();
  sp_stream_unpacker_if #(.DATA_W(16)) out_if ();

  assign out_if.done = out_if.request;

  sp_stream_unpacker #(
    .DATA_W      (16),
    .MODULE_ADDR (8'h01),
    .BCAST_ADDR  (8'hFF),
    .TIMEOUT     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .enable    (enable),
    .in_bus    (in_if),
    .out_bus   (out_if),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .hdr_addr  (hdr_addr),
    .hdr_cmd   (hdr_cmd),
    .hdr_size  (hdr_size),
    .word_idx  (word_idx),
    .pkt_num   (pkt_num),
    .num_valid (num_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(ev_t e);
    return $sformatf("@%0d req=%0b data=%h idx=%0d start=%0b end=%0b err=%0b code=%0d nv=%0b num=%h",
                     e.stamp, e.oreq, e.odata, e.idx, e.start, e.pend, e.perr, e.code, e.nv, e.num);
  endfunction

  function automatic ev_t ev_data(int st, logic [15:0] d, logic [7:0] i, logic s);
    ev_t e = '0;
    e.stamp = 32'(st); e.oreq = 1'b1; e.odata = d; e.idx = i; e.start = s;
    return e;
  endfunction

  function automatic ev_t ev_pulse(int st, logic pe, logic pr, logic [2:0] c);
    ev_t e = '0;
    e.stamp = 32'(st); e.pend = pe; e.perr = pr; e.code = c;
    return e;
  endfunction

  function automatic ev_t ev_num(int st, logic [15:0] n);
    ev_t e = '0;
    e.stamp = 32'(st); e.nv = 1'b1; e.num = n;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cycle with output activity must match the oldest expected event exactly.
  always @(negedge clk) begin
    ev_t got, want;
    if (rst_n) begin
      got = '0;
      got.stamp = 32'(cyc);
      got.oreq  = out_if.request;
      if (out_if.request) begin
        got.odata = out_if.data;
        got.idx   = word_idx;
      end
      got.start = pkt_start;
      got.pend  = pkt_end;
      got.perr  = pkt_err;
      if (pkt_err) got.code = err_code;
      got.nv = num_valid;
      if (num_valid) got.num = pkt_num;
      if (got.oreq || got.start || got.pend || got.perr || got.nv) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %s expected none", fmt(got));
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL event: got %s expected %s", fmt(got), fmt(want));
          end
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    in_if.request = 1'b1;
    in_if.data    = w;
    @(posedge clk); #1;
    in_if.request = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] crc, w;
    w = {8'h00, v.addr};
    crc = w;
    send_word(w);
    w = {v.size, v.cmd};
    crc = crc + w;
    if (v.code == 3'd1) begin
      sb.push_back(ev_pulse(cyc + 1, 1'b0, 1'b1, 3'd1));
      send_word(w);
      return;
    end
    send_word(w);
    for (int i = 0; i < int'(v.size); i++) begin
      w = v.pl[i];
      crc = crc + w;
      if (v.fwd) sb.push_back(ev_data(cyc + 1, w, 8'(i), i == 0));
      send_word(w);
    end
    w = crc + v.crc_adj;
    if (v.fwd) sb.push_back(ev_pulse(cyc + 1, v.code == 3'd0, v.code != 3'd0, v.code));
    send_word(w);
    if (v.fwd) begin
      sb.push_back(ev_num(cyc + 1, v.num));
      last_num = v.num;
    end
    send_word(v.num);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int st;
    vecs[0] = '{8'h01, 8'h02, 8'd3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 16'h0, 16'h0007, 1'b1, 3'd0};
    vecs[1] = '{8'h01, 8'h02, 8'd3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 16'h1, 16'h0008, 1'b1, 3'd2};
    vecs[2] = '{8'h05, 8'h01, 8'd2, {16'h0, 16'h0, 16'hBBBB, 16'hAAAA}, 16'h0, 16'h0009, 1'b0, 3'd0};
    vecs[3] = '{8'h01, 8'h03, 8'd1, {16'h0, 16'h0, 16'h0, 16'h00FF}, 16'h0, 16'h000A, 1'b1, 3'd0};
    vecs[4] = '{8'hFF, 8'h04, 8'd4, {16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF}, 16'h0, 16'h1234,
                1'b1, 3'd0};
    vecs[5] = '{8'h01, 8'h01, 8'd0, 64'h0, 16'h0, 16'h0055, 1'b1, 3'd0};
    vecs[6] = '{8'h01, 8'h55, 8'd2, 64'h0, 16'h0, 16'h0, 1'b0, 3'd1};
    vecs[7] = '{8'h01, 8'h02, 8'd2, {16'h0, 16'h0, 16'h0BAD, 16'hCAFE}, 16'h0, 16'h00AB, 1'b1, 3'd0};

    in_if.request = 1'b0;
    in_if.data    = 16'h0;
    #2 rst_n = 1'b0;
    idle(3);
    chk("rst out_request", 32'(out_if.request), 0);
    chk("rst out_data", 32'(out_if.data), 0);
    chk("rst pulses", 32'({pkt_start, pkt_end, pkt_err, num_valid}), 0);
    chk("rst err_code", 32'(err_code), 0);
    chk("rst headers", {hdr_addr, hdr_cmd, hdr_size, word_idx}, 0);
    chk("rst pkt_num", 32'(pkt_num), 0);

    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      idle(4);
      chk($sformatf("vec%0d drain", i), 32'(sb.size()), 0);
      chk($sformatf("vec%0d hdr_addr", i), 32'(hdr_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d hdr_cmd", i), 32'(hdr_cmd), 32'(vecs[i].cmd));
      chk($sformatf("vec%0d hdr_size", i), 32'(hdr_size), 32'(vecs[i].size));
      chk($sformatf("vec%0d pkt_num", i), 32'(pkt_num), 32'(last_num));
    end

    // Stall after the first payload word: error after 16 idle clocks.
    send_word(16'h0001);
    send_word({8'd3, 8'h02});
    st = cyc + 1;
    sb.push_back(ev_data(st, 16'h1111, 8'd0, 1'b1));
    send_word(16'h1111);
    sb.push_back(ev_pulse(st + 16, 1'b0, 1'b1, 3'd3));
    idle(24);
    chk("timeout drain", 32'(sb.size()), 0);
    run_vec(vecs[0]);
    idle(4);
    chk("post-timeout drain", 32'(sb.size()), 0);

    // enable drops together with a payload word: abort wins, no forwarding.
    send_word(16'h0001);
    send_word({8'd3, 8'h02});
    sb.push_back(ev_pulse(cyc + 1, 1'b0, 1'b1, 3'd4));
    enable = 1'b0;
    send_word(16'h1111);
    idle(3);
    send_word(16'h0001);
    idle(2);
    chk("abort drain", 32'(sb.size()), 0);
    enable = 1'b1;
    idle(2);
    run_vec(vecs[7]);
    idle(4);
    chk("post-abort drain", 32'(sb.size()), 0);
    chk("post-abort pkt_num", 32'(pkt_num), 32'h00AB);

    // Asynchronous reset while a payload word is on the output bus.
    send_word(16'h0001);
    send_word({8'd3, 8'h02});
    send_word(16'h1111);
    #1;
    chk("pre-reset out_request", 32'(out_if.request), 1);
    rst_n = 1'b0;
    #1;
    chk("areset out_request", 32'(out_if.request), 0);
    chk("areset out_data", 32'(out_if.data), 0);
    chk("areset pulses", 32'({pkt_start, pkt_end, pkt_err, num_valid}), 0);
    chk("areset err_code", 32'(err_code), 0);
    chk("areset headers", {hdr_addr, hdr_cmd, hdr_size, word_idx}, 0);
    chk("areset pkt_num", 32'(pkt_num), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    run_vec(vecs[3]);
    idle(4);
    chk("post-reset drain", 32'(sb.size()), 0);
    chk("post-reset pkt_num", 32'(pkt_num), 32'h000A);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
